cf_spi_target_wb: RTL and testbench

SPI target (peripheral-side) controller with a Wishbone B4 classic register slave; the counterpart of the team's SPI controller core, letting the SoC act as the device on an external SPI bus. It oversamples the external `sclk`/`csb`/`mosi` on `clk`, shifts 8-bit frames MSB-first in all four CPOL/CPHA modes, and buffers traffic in RX and TX FIFOs with interrupt reporting.

---
 rtl/cf_spi_target_wb_if.sv | 13 +
 rtl/cf_spi_target_wb.sv | 179 +++++++++++++++++
 tb/tb_cf_spi_target_wb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cf_spi_target_wb_if.sv
// cf_spi_target_wb_if: Wishbone B4 classic bus bundle for the SPI target register slave
interface cf_spi_target_wb_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        ack_o;
  modport master(output adr_i, dat_i, sel_i, cyc_i, stb_i, we_i, input dat_o, ack_o);
  modport slave(input adr_i, dat_i, sel_i, cyc_i, stb_i, we_i, output dat_o, ack_o);
endinterface

// File: rtl/cf_spi_target_wb.sv
// cf_spi_target_wb: oversampled SPI target with RX/TX FIFOs behind a Wishbone register slave
module cf_spi_target_wb #(
  parameter int FAW = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  cf_spi_target_wb_if.slave        bus,
  output logic                     IRQ,
  input  logic                     sclk,
  input  logic                     csb,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe
);
  localparam int DEPTH = 1 << FAW;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [2:0] sclk_q, csb_q;
  logic [1:0] mosi_q;
  logic en, cpol, cpha, done, ovr, udr;
  logic [4:0] im, ris, ic;
  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];
  logic [FAW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [FAW:0] rx_cnt, tx_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, rx_byte, tx_next;
  logic [15:0] a;
  logic [31:0] rdata;
  logic acc, wr, rd, rx_empty, rx_full, tx_empty, tx_full;
  logic rx_pop, tx_push, rx_flush, tx_flush;
  logic sclk_rise, sclk_fall, lead, trail, samp_e, drv_e, csb_fall, csb_rise;
  logic act, start, stop, samp, last, load, drv;
  logic spi_rx_push, spi_tx_pop, udr_set, ovr_set, done_set;
  logic unused;
  assign unused = ^{bus.sel_i, bus.adr_i[31:16], bus.dat_i[31:8]};
  assign a = bus.adr_i[15:0];
  assign acc = bus.cyc_i & bus.stb_i & ~bus.ack_o;
  assign wr = acc & bus.we_i;
  assign rd = acc & ~bus.we_i;
  assign rx_empty = rx_cnt == '0;
  assign rx_full = rx_cnt == (FAW+1)'(DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign tx_full = tx_cnt == (FAW+1)'(DEPTH);
  assign rx_pop = rd & (a == 16'h0000) & ~rx_empty;
  assign tx_push = wr & (a == 16'h0004) & ~tx_full;
  assign rx_flush = wr & (a == 16'h000C) & bus.dat_i[1];
  assign tx_flush = wr & (a == 16'h000C) & bus.dat_i[2];
  assign ic = (wr & (a == 16'hFF0C)) ? bus.dat_i[4:0] : 5'h0;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign lead = cpol ? sclk_fall : sclk_rise;
  assign trail = cpol ? sclk_rise : sclk_fall;
  assign samp_e = cpha ? trail : lead;
  assign drv_e = cpha ? lead : trail;
  assign csb_fall = ~csb_q[1] & csb_q[2];
  assign csb_rise = csb_q[1] & ~csb_q[2];
  assign act = (state == ACTIVE) & en;
  assign start = (state == IDLE) & en & csb_fall;
  assign stop = (state == ACTIVE) & (~en | csb_rise);
  assign samp = act & ~csb_rise & samp_e;
  assign last = samp & (bit_cnt == 3'd7);
  assign load = start | last;
  assign drv = act & ~csb_rise & drv_e & (bit_cnt != 3'd0);
  assign rx_byte = {rx_shift[6:0], mosi_q[1]};
  assign tx_next = tx_empty ? 8'hFF : tx_mem[tx_rp];
  // a completed byte may enter a full RX FIFO only when the bus pops in the same cycle
  assign spi_rx_push = last & (~rx_full | rx_pop);
  assign ovr_set = last & rx_full & ~rx_pop;
  assign spi_tx_pop = load & ~tx_empty;
  assign udr_set = load & tx_empty;
  assign done_set = act & csb_rise;
  assign ris = {udr, ovr, done, tx_empty, ~rx_empty};
  assign IRQ = |(ris & im);
  assign miso = tx_shift[7];
  assign miso_oe = en & ~csb_q[1];
  // two-flop synchronizers; the third sclk/csb flop exposes edges
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      sclk_q <= 3'b000;
      csb_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      csb_q <= {csb_q[1:0], csb};
      mosi_q <= {mosi_q[0], mosi};
    end
  // frame FSM and shift registers
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= 8'hFF;
    end else begin
      state <= start ? ACTIVE : stop ? IDLE : state;
      bit_cnt <= (start | stop) ? 3'd0 : samp ? bit_cnt + 3'd1 : bit_cnt;
      if (samp) rx_shift <= rx_byte;
      tx_shift <= load ? tx_next : drv ? {tx_shift[6:0], 1'b0} : tx_shift;
    end
  // RX FIFO pointers; flush overrides any same-cycle push or pop
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else begin
      if (spi_rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + (FAW+1)'(spi_rx_push) - (FAW+1)'(rx_pop);
    end
  // TX FIFO pointers; flush overrides any same-cycle push or pop
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (spi_tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + (FAW+1)'(tx_push) - (FAW+1)'(spi_tx_pop);
    end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (spi_rx_push) rx_mem[rx_wp] <= rx_byte;
    if (tx_push) tx_mem[tx_wp] <= bus.dat_i[7:0];
  end
  // control registers and sticky interrupt flags; a new event beats a same-cycle clear
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      en <= 1'b0;
      cpol <= 1'b0;
      cpha <= 1'b0;
      im <= 5'h0;
      done <= 1'b0;
      ovr <= 1'b0;
      udr <= 1'b0;
    end else begin
      if (wr & (a == 16'h0008)) {cpha, cpol} <= bus.dat_i[1:0];
      if (wr & (a == 16'h000C)) en <= bus.dat_i[0];
      if (wr & (a == 16'hFF00)) im <= bus.dat_i[4:0];
      done <= (done & ~ic[2]) | done_set;
      ovr <= (ovr & ~ic[3]) | ovr_set;
      udr <= (udr & ~ic[4]) | udr_set;
    end
  // read mux
  always_comb begin
    rdata = '0;
    case (a)
      16'h0000: rdata = {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rp]};
      16'h0008: rdata = {30'h0, cpha, cpol};
      16'h000C: rdata = {31'h0, en};
      16'h0014: rdata = {27'h0, ~csb_q[1], tx_full, tx_empty, rx_full, rx_empty};
      16'hFE00: rdata = {{(31-FAW){1'b0}}, rx_cnt};
      16'hFE10: rdata = {{(31-FAW){1'b0}}, tx_cnt};
      16'hFF00: rdata = {27'h0, im};
      16'hFF04: rdata = {27'h0, ris & im};
      16'hFF08: rdata = {27'h0, ris};
      default: rdata = '0;
    endcase
  end
  // one-cycle acknowledge with read data captured at accept
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      bus.ack_o <= 1'b0;
      bus.dat_o <= '0;
    end else begin
      bus.ack_o <= acc;
      bus.dat_o <= rd ? rdata : '0;
    end
endmodule

// File: tb/tb_cf_spi_target_wb.sv
// tb_cf_spi_target_wb: directed bench with a queue-based model of the SPI target and its registers
module tb_cf_spi_target_wb;
  logic clk = 0, rst_i = 1, sclk = 0, csb = 1, mosi = 0;
  logic irq, miso, miso_oe;
  cf_spi_target_wb_if wb();
  cf_spi_target_wb #(.FAW(4)) dut (
    .clk(clk), .rst_i(rst_i), .bus(wb), .IRQ(irq),
    .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [32:0] exp_q[$];
  logic [7:0] mo [32];
  bit done, ovr, udr, en, cpol, cpha;
  logic [4:0] im;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask
  function automatic logic [4:0] ris_m();
    return {udr, ovr, done, tx_q.size() == 0, rx_q.size() != 0};
  endfunction
  function automatic logic irq_m();
    return |(ris_m() & im);
  endfunction
  function automatic logic [31:0] rd_m(input logic [15:0] a);
    case (a)
      16'h0000: return (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
      16'h0008: return {30'h0, cpha, cpol};
      16'h000C: return {31'h0, en};
      16'h0014: return {27'h0, 1'b0, tx_q.size() == 16, tx_q.size() == 0, rx_q.size() == 16, rx_q.size() == 0};
      16'hFE00: return 32'(rx_q.size());
      16'hFE10: return 32'(tx_q.size());
      16'hFF00: return {27'h0, im};
      16'hFF04: return {27'h0, ris_m() & im};
      16'hFF08: return {27'h0, ris_m()};
      default: return 32'h0;
    endcase
  endfunction
  function automatic void wr_m(input logic [15:0] a, input logic [31:0] d);
    case (a)
      16'h0004: if (tx_q.size() < 16) tx_q.push_back(d[7:0]);
      16'h0008: {cpha, cpol} = d[1:0];
      16'h000C: begin
        en = d[0];
        if (d[1]) rx_q.delete();
        if (d[2]) tx_q.delete();
      end
      16'hFF00: im = d[4:0];
      16'hFF0C: begin
        if (d[2]) done = 0;
        if (d[3]) ovr = 0;
        if (d[4]) udr = 0;
      end
      default: ;
    endcase
  endfunction
  function automatic logic [7:0] load_m();
    if (tx_q.size() != 0) return tx_q.pop_front();
    udr = 1;
    return 8'hFF;
  endfunction
  function automatic void push_m(input logic [7:0] b);
    if (rx_q.size() < 16) rx_q.push_back(b);
    else ovr = 1;
  endfunction
  task automatic access(input bit w, input logic [15:0] a, input logic [31:0] d, input bit lit, input logic [31:0] lv);
    logic [31:0] e;
    int n;
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = w; wb.adr_i = {16'h0, a}; wb.dat_i = d;
    if (w) begin
      wr_m(a, d);
      exp_q.push_back(33'h0);
    end else begin
      e = rd_m(a);
      exp_q.push_back({1'b1, lit ? lv : e});
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.ack_o && n < 4);
    check("ack", 32'(wb.ack_o), 32'd1);
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0;
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    access(1, a, d, 0, 0);
  endtask
  task automatic rd(input logic [15:0] a);
    access(0, a, 0, 0, 0);
  endtask
  task automatic rdl(input logic [15:0] a, input logic [31:0] v);
    access(0, a, 0, 1, v);
  endtask
  // every acknowledged read is compared against the expectation queued when it was issued
  always @(negedge clk) begin
    logic [32:0] e;
    if (wb.ack_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ack at %0t: got ack 1, expected no ack", $time);
      end else begin
        e = exp_q.pop_front();
        if (e[32]) check("rdata", wb.dat_o, e[31:0]);
      end
    end
  end
  task automatic spi_bit(input logic b, output logic m_early, output logic m);
    if (!cpha) begin
      mosi = b;
      repeat (3) @(negedge clk);
      m_early = miso;
      @(negedge clk);
      m = miso;
      sclk = ~cpol;
      repeat (4) @(negedge clk);
      sclk = cpol;
    end else begin
      sclk = ~cpol;
      mosi = b;
      repeat (3) @(negedge clk);
      m_early = miso;
      @(negedge clk);
      m = miso;
      sclk = cpol;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic frame(input int nb, input int tail);
    logic [7:0] got, early, cur;
    logic me, mm;
    sclk = cpol;
    repeat (4) @(negedge clk);
    csb = 0;
    cur = load_m();
    repeat (5) @(negedge clk);
    check("miso_oe_active", 32'(miso_oe), 32'(en));
    for (int i = 0; i < nb; i++) begin
      for (int j = 7; j >= 0; j--) begin
        spi_bit(mo[i][j], me, mm);
        got[j] = mm;
        early[j] = me;
      end
      check("miso_byte", 32'(got), 32'(cur));
      check("miso_stable", 32'(early), 32'(cur));
      push_m(mo[i]);
      cur = load_m();
    end
    for (int j = 0; j < tail; j++) spi_bit(mo[nb][7-j], me, mm);
    repeat (4) @(negedge clk);
    csb = 1;
    done = 1;
    repeat (8) @(negedge clk);
    check("miso_oe_idle", 32'(miso_oe), 32'd0);
  endtask
  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    logic me, mm;
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0; wb.adr_i = 0; wb.dat_i = 0; wb.sel_i = 4'hF;
    im = 0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(wb.ack_o), 0);
    check("rst_dat", wb.dat_o, 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_miso", 32'(miso), 1);
    check("rst_miso_oe", 32'(miso_oe), 0);
    rst_i = 0;
    @(negedge clk);
    rdl(16'h0014, 32'h05);
    rdl(16'hFF08, 32'h02);
    wr(16'h000C, 1);
    for (int m = 0; m < 4; m++) begin
      wr(16'hFF0C, 32'h1C);
      wr(16'h0008, m);
      rd(16'h0008);
      wr(16'h0004, 32'hA5);
      wr(16'h0004, 32'h3C);
      mo[0] = 8'h5A;
      mo[1] = 8'hC3;
      frame(2, 0);
      rdl(16'hFF08, 32'h17);
      rdl(16'hFE00, 2);
      rdl(16'h0000, 32'h5A);
      rdl(16'h0000, 32'hC3);
      rdl(16'hFE10, 0);
    end
    wr(16'h0008, 0);
    wr(16'hFF0C, 32'h1C);
    for (int i = 0; i < 17; i++) mo[i] = 8'(i * 37 + 5);
    frame(17, 0);
    rdl(16'hFE00, 16);
    rdl(16'hFF08, 32'h1F);
    rd(16'h0014);
    for (int i = 0; i < 16; i++) rd(16'h0000);
    rdl(16'h0000, 0);
    wr(16'hFF0C, 32'h1C);
    wr(16'h0004, 32'h81);
    wr(16'h0004, 32'h42);
    mo[0] = 8'h6B;
    frame(0, 5);
    rdl(16'hFE00, 0);
    rdl(16'hFF08, 32'h04);
    mo[0] = 8'h99;
    frame(1, 0);
    rdl(16'h0000, 32'h99);
    wr(16'hFF0C, 32'h1F);
    wr(16'hFF00, 32'h04);
    check("irq_masked", 32'(irq), 32'(irq_m()));
    mo[0] = 8'h12;
    frame(1, 0);
    check("irq_done", 32'(irq), 1);
    wr(16'hFF0C, 32'h04);
    check("irq_cleared", 32'(irq), 0);
    wr(16'hFF00, 32'h01);
    check("irq_rxne", 32'(irq), 1);
    rd(16'hFF04);
    wr(16'hFF0C, 32'h1F);
    check("irq_rxne_noclear", 32'(irq), 1);
    rd(16'h0000);
    check("irq_after_pop", 32'(irq), 32'(irq_m()));
    for (int i = 0; i < 17; i++) wr(16'h0004, i);
    rdl(16'hFE10, 16);
    rd(16'h0014);
    wr(16'h000C, 32'h5);
    rdl(16'hFE10, 0);
    wr(16'h0004, 32'h11);
    wr(16'h000C, 32'h5);
    rdl(16'hFE10, 0);
    wr(16'hFF00, 32'h02);
    wr(16'h0004, 32'h00);
    sclk = 0;
    repeat (4) @(negedge clk);
    csb = 0;
    repeat (5) @(negedge clk);
    check("pre_rst_miso", 32'(miso), 0);
    check("pre_rst_oe", 32'(miso_oe), 1);
    check("pre_rst_irq", 32'(irq), 1);
    spi_bit(1'b1, me, mm);
    spi_bit(1'b0, me, mm);
    #2 rst_i = 1;
    #1;
    check("mid_rst_ack", 32'(wb.ack_o), 0);
    check("mid_rst_dat", wb.dat_o, 0);
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_miso", 32'(miso), 1);
    check("mid_rst_oe", 32'(miso_oe), 0);
    repeat (2) @(negedge clk);
    csb = 1;
    sclk = 0;
    rst_i = 0;
    tx_q.delete(); rx_q.delete();
    done = 0; ovr = 0; udr = 0; en = 0; cpol = 0; cpha = 0; im = 0;
    repeat (4) @(negedge clk);
    rdl(16'h0014, 32'h05);
    rdl(16'hFF00, 0);
    rd(16'h000C);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
